// File: rtl/memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : memory_bus_arbiter
// Description : Round-robin arbiter sharing one memory port between the
//               instruction-fetch port (F) and the load/store port (D).
//               Request fields are captured at grant. The winner receives
//               read data and a one-cycle Done pulse.
//               Optional feature macro: BUS_TIMEOUT_EN (abort an access
//               after TIMEOUT_CYCLES ACCESS cycles without OK).
// Revision    : 1.0 - initial release
// ============================================================================
module memory_bus_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              CoreClock,
  input  logic              CoreReset,
  input  logic              FetchReq,
  input  logic [ADDR_W-1:0] FetchAddr,
  output logic [DATA_W-1:0] FetchData,
  output logic              FetchDone,
  input  logic              DataReq,
  input  logic              DataWe,
  input  logic [ADDR_W-1:0] DataAddr,
  input  logic [DATA_W-1:0] DataWriteData,
  output logic [DATA_W-1:0] DataReadData,
  output logic              DataDone,
  output logic [ADDR_W-1:0] AddressBus,
  output logic [DATA_W-1:0] DataWriteBus,
  output logic              ReadAssert,
  output logic              WriteAssert,
  input  logic [DATA_W-1:0] DataReadBus,
  input  logic              ReadOK,
  input  logic              WriteOK,
  output logic              Grant,
  output logic              BusError
);

  localparam logic [1:0] c_IDLE     = 2'd0;
  localparam logic [1:0] c_ACCESS   = 2'd1;
  localparam logic [1:0] c_COMPLETE = 2'd2;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_fetchData;
  logic [DATA_W-1:0] r_dataRead;
  logic              r_we;
  logic              r_grant;
  logic              r_lastGrant;

  logic w_pickData;
  logic w_okHit;
  logic w_timeout;

  // Data wins when it is alone, or on a tie when fetch owned the last access.
  assign w_pickData = DataReq & (~FetchReq | ~r_lastGrant);

  // Only the OK matching the active direction can end the access.
  assign w_okHit = r_we ? WriteOK : ReadOK;

`ifdef BUS_TIMEOUT_EN
  localparam int c_CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [c_CNT_W-1:0] r_waitCnt;
  logic               r_busError;

  // Counter holds the number of ACCESS cycles already spent without OK, so
  // the edge ending cycle TIMEOUT_CYCLES is the abort point.
  assign w_timeout = (r_waitCnt == c_CNT_W'(TIMEOUT_CYCLES - 1));

  // Count OK-less ACCESS cycles; cleared while idle so each access starts at 0.
  always_ff @(posedge CoreClock or posedge CoreReset) begin
    if (CoreReset) begin
      r_waitCnt <= '0;
    end else if (r_state != c_ACCESS) begin
      r_waitCnt <= '0;
    end else if (!w_okHit) begin
      r_waitCnt <= r_waitCnt + 1'b1;
    end
  end

  // Error flag is high only for the Done cycle following a timeout abort.
  always_ff @(posedge CoreClock or posedge CoreReset) begin
    if (CoreReset) begin
      r_busError <= 1'b0;
    end else begin
      r_busError <= (r_state == c_ACCESS) & ~w_okHit & w_timeout;
    end
  end

  assign BusError = r_busError;
`else
  assign w_timeout = 1'b0;
  assign BusError  = 1'b0;
`endif

  // Arbitration, request capture and access sequencing.
  always_ff @(posedge CoreClock or posedge CoreReset) begin
    if (CoreReset) begin
      r_state     <= c_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_fetchData <= '0;
      r_dataRead  <= '0;
      r_we        <= 1'b0;
      r_grant     <= 1'b0;
      r_lastGrant <= 1'b1;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (FetchReq || DataReq) begin
            r_state     <= c_ACCESS;
            r_grant     <= w_pickData;
            r_lastGrant <= w_pickData;
            r_addr      <= w_pickData ? DataAddr : FetchAddr;
            r_we        <= w_pickData & DataWe;
            // Fetch has no write data; the write bus keeps its last value.
            if (w_pickData) begin
              r_wdata <= DataWriteData;
            end
          end
        end
        c_ACCESS: begin
          if (w_okHit) begin
            r_state <= c_COMPLETE;
            if (!r_we) begin
              if (r_grant) begin
                r_dataRead <= DataReadBus;
              end else begin
                r_fetchData <= DataReadBus;
              end
            end
          end else if (w_timeout) begin
            r_state <= c_COMPLETE;
          end
        end
        c_COMPLETE: begin
          r_state <= c_IDLE;
        end
        default: begin
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign AddressBus   = r_addr;
  assign DataWriteBus = r_wdata;
  assign ReadAssert   = (r_state == c_ACCESS) & ~r_we;
  assign WriteAssert  = (r_state == c_ACCESS) &  r_we;
  assign FetchDone    = (r_state == c_COMPLETE) & ~r_grant;
  assign DataDone     = (r_state == c_COMPLETE) &  r_grant;
  assign FetchData    = r_fetchData;
  assign DataReadData = r_dataRead;
  assign Grant        = r_grant;

endmodule
`default_nettype wire

// File: tb/tb_memory_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_memory_bus_arbiter
// Description : Self-checking bench for memory_bus_arbiter. A word-array
//               memory and a round-robin ownership variable predict every
//               bus cycle, completion pulse and returned word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_memory_bus_arbiter;

  localparam int TO = 5;

  logic        CoreClock = 1'b0;
  logic        CoreReset;
  logic        FetchReq, DataReq, DataWe;
  logic [31:0] FetchAddr, DataAddr, DataWriteData, DataReadBus;
  logic        ReadOK, WriteOK;
  logic [31:0] FetchData, DataReadData, AddressBus, DataWriteBus;
  logic        FetchDone, DataDone, ReadAssert, WriteAssert, Grant, BusError;

  int checks = 0;
  int errors = 0;

  // Reference state: memory contents, last owner, last returned words.
  logic [31:0] mem [256];
  logic        mLast;
  logic [31:0] expF, expD;

  memory_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO)) dut (
    .CoreClock(CoreClock), .CoreReset(CoreReset),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchData(FetchData), .FetchDone(FetchDone),
    .DataReq(DataReq), .DataWe(DataWe), .DataAddr(DataAddr), .DataWriteData(DataWriteData),
    .DataReadData(DataReadData), .DataDone(DataDone),
    .AddressBus(AddressBus), .DataWriteBus(DataWriteBus),
    .ReadAssert(ReadAssert), .WriteAssert(WriteAssert), .DataReadBus(DataReadBus),
    .ReadOK(ReadOK), .WriteOK(WriteOK), .Grant(Grant), .BusError(BusError)
  );

  always #5 CoreClock = ~CoreClock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic scramble();
    FetchAddr     = 32'($urandom_range(0, 255));
    DataAddr      = 32'($urandom_range(0, 255));
    DataWriteData = $urandom;
    DataWe        = 1'($urandom_range(0, 1));
  endtask

  // Runs one full access starting from an IDLE negedge with requests set.
  // OK arrives after 'waits' wait cycles; ends at the following IDLE negedge.
  task automatic access(input int waits, input bit hold);
    logic        win, we, ok, timedOut;
    logic [31:0] a, wd;
    win = (FetchReq && DataReq) ? ~mLast : !FetchReq;
    a   = win ? DataAddr : FetchAddr;
    we  = win & DataWe;
    wd  = DataWriteData;
    mLast = win;
    ok = 1'b0;
    timedOut = 1'b0;
    @(posedge CoreClock); @(negedge CoreClock);
    scramble();
    for (int k = 1; k <= waits + 1; k++) begin
      chk("acc_read_strobe", {31'b0, ReadAssert}, {31'b0, !we});
      chk("acc_write_strobe", {31'b0, WriteAssert}, {31'b0, we});
      chk("acc_addr", AddressBus, a);
      if (we) chk("acc_wdata", DataWriteBus, wd);
      chk("acc_grant", {31'b0, Grant}, {31'b0, win});
      chk("acc_done", {30'b0, FetchDone, DataDone}, 32'd0);
      chk("acc_fdata_hold", FetchData, expF);
      ok = (k == waits + 1);
      ReadOK      = ok ? !we : (we & 1'($urandom_range(0, 1)));
      WriteOK     = ok ?  we : (!we & 1'($urandom_range(0, 1)));
      DataReadBus = (ok && !we) ? mem[a[7:0]] : $urandom;
      @(posedge CoreClock); @(negedge CoreClock);
      ReadOK = 1'b0; WriteOK = 1'b0;
      if (ok) break;
`ifdef BUS_TIMEOUT_EN
      if (k == TO) begin timedOut = 1'b1; break; end
`endif
    end
    if (ok) begin
      if (we) mem[a[7:0]] = wd;
      else if (win) expD = mem[a[7:0]];
      else expF = mem[a[7:0]];
    end
    chk("cmp_fetch_done", {31'b0, FetchDone}, {31'b0, !win});
    chk("cmp_data_done", {31'b0, DataDone}, {31'b0, win});
    chk("cmp_strobes", {30'b0, ReadAssert, WriteAssert}, 32'd0);
    chk("cmp_bus_error", {31'b0, BusError}, {31'b0, timedOut});
    chk("cmp_fetch_data", FetchData, expF);
    chk("cmp_data_read", DataReadData, expD);
    chk("cmp_addr_hold", AddressBus, a);
    if (!hold) begin
      FetchReq = 1'($urandom_range(0, 1));
      DataReq  = 1'($urandom_range(0, 1));
      if (!FetchReq && !DataReq) FetchReq = 1'b1;
    end
    @(posedge CoreClock); @(negedge CoreClock);
    chk("idle_strobes", {30'b0, ReadAssert, WriteAssert}, 32'd0);
    chk("idle_done", {29'b0, FetchDone, DataDone, BusError}, 32'd0);
    chk("idle_addr_hold", AddressBus, a);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
    CoreReset = 1'b1;
    FetchReq = 1'b0; DataReq = 1'b0; DataWe = 1'b0;
    FetchAddr = '0; DataAddr = '0; DataWriteData = '0; DataReadBus = '0;
    ReadOK = 1'b0; WriteOK = 1'b0;
    mLast = 1'b1; expF = '0; expD = '0;

    // Reset state
    @(negedge CoreClock); @(negedge CoreClock);
    chk("rst_addr", AddressBus, 32'd0);
    chk("rst_wdata", DataWriteBus, 32'd0);
    chk("rst_fdata", FetchData, 32'd0);
    chk("rst_ddata", DataReadData, 32'd0);
    chk("rst_ctrl", {26'b0, ReadAssert, WriteAssert, FetchDone, DataDone, Grant, BusError}, 32'd0);
    CoreReset = 1'b0;
    @(negedge CoreClock);

    // Single zero-wait fetch
    mem[8'h10] = 32'hDEADBEEF;
    FetchReq = 1'b1; FetchAddr = 32'h10;
    access(0, 1'b0);
    chk("fetch_word", FetchData, 32'hDEADBEEF);

    // Store with three wait states
    FetchReq = 1'b0; DataReq = 1'b1; DataWe = 1'b1;
    DataAddr = 32'h20; DataWriteData = 32'h12345678;
    access(3, 1'b0);

    // Contention: both held, grants alternate starting with fetch
    FetchReq = 1'b1; DataReq = 1'b1; FetchAddr = 32'h4;
    for (int i = 0; i < 4; i++) access(0, 1'b1);

    // Long wait (aborts by timeout when the feature is built), then normal
    FetchReq = 1'b0; DataReq = 1'b1; DataWe = 1'b0; DataAddr = 32'h33;
`ifdef BUS_TIMEOUT_EN
    access(20, 1'b0);
`else
    access(10, 1'b0);
`endif
    FetchReq = 1'b0; DataReq = 1'b1; DataWe = 1'b0; DataAddr = 32'h34;
    access(1, 1'b0);

    // Reset in the middle of an access
    FetchReq = 1'b1; DataReq = 1'b1; DataWe = 1'b1;
    @(posedge CoreClock); @(negedge CoreClock);
    chk("pre_rst_strobe", {30'b0, ReadAssert, WriteAssert}, 32'd2);
    CoreReset = 1'b1;
    #1;
    chk("mid_rst_strobes", {30'b0, ReadAssert, WriteAssert}, 32'd0);
    chk("mid_rst_done", {30'b0, FetchDone, DataDone}, 32'd0);
    chk("mid_rst_fdata", FetchData, 32'd0);
    @(negedge CoreClock);
    chk("mid_rst_done2", {30'b0, FetchDone, DataDone}, 32'd0);
    CoreReset = 1'b0;
    mLast = 1'b1; expF = '0; expD = '0;
    @(negedge CoreClock);
    access(0, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      scramble();
      access($urandom_range(0, 3), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    errors++;
    $display("FAIL watchdog observed timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/memory_bus_arbiter.md
Name: memory_bus_arbiter

Overview:
- Shares the core's single memory port between two requesters: instruction fetch (port F) and load/store (port D).
- Sits between the multi-cycle core's fetch/LSU logic and the memory system. Drives AddressBus, DataWriteBus, ReadAssert and WriteAssert, and consumes ReadOK and WriteOK.
- Arbitrates round-robin and registers the request fields at grant. Returns read data and a one-cycle Done pulse to the winning requester.

Parameters:
- ADDR_W, 32, width of the address bus and of the request addresses (word address; passed through unchanged).
- DATA_W, 32, width of all data paths.
- TIMEOUT_CYCLES, 255, number of ACCESS cycles without OK before the access is aborted (used only with BUS_TIMEOUT_EN).

Ports:
- CoreClock  in  1  core clock; all state updates on the rising edge.
- CoreReset  in  1  reset, asynchronous and active-high.
- FetchReq  in  1  fetch request; held high until FetchDone.
- FetchAddr  in  ADDR_W  fetch word address.
- FetchData  out  DATA_W  last fetched word; held between completions.
- FetchDone  out  1  one-cycle completion pulse for the fetch port.
- DataReq  in  1  load/store request; held high until DataDone.
- DataWe  in  1  1 = store, 0 = load.
- DataAddr  in  ADDR_W  load/store word address.
- DataWriteData  in  DATA_W  store data.
- DataReadData  out  DATA_W  last loaded word; held between completions.
- DataDone  out  1  one-cycle completion pulse for the data port.
- AddressBus  out  ADDR_W  memory address.
- DataWriteBus  out  DATA_W  memory write data.
- ReadAssert  out  1  memory read strobe.
- WriteAssert  out  1  memory write strobe.
- DataReadBus  in  DATA_W  memory read data.
- ReadOK  in  1  read complete; DataReadBus is valid in the same cycle.
- WriteOK  in  1  write complete.
- Grant  out  1  owner of the current or last access: 0 = fetch, 1 = data.
- BusError  out  1  valid with a Done pulse; 1 = access aborted by timeout.

Behaviour:
- Reset (async, immediate):
  - State = IDLE.
  - All outputs 0, including AddressBus, DataWriteBus, FetchData and DataReadData.
  - LastGrant = 1, so fetch wins the first tie.
- Reset asserted mid-access: the access is dropped immediately, no Done pulse is issued, and both strobes deassert at once.
- IDLE:
  - If any Req is high, arbitrate.
  - Only one requester high: it wins.
  - Both high: the port opposite LastGrant wins.
  - At the edge, register the winner's address, write data and We into the bus registers; set Grant and LastGrant; go to ACCESS.
- ACCESS:
  - Bus outputs come from registers only.
  - ReadAssert = ~We and WriteAssert = We, held stable for the whole state.
  - Read access: at the edge where ReadOK = 1, capture DataReadBus into the granted port's read-data register and go to COMPLETE.
  - Write access: at the edge where WriteOK = 1, go to COMPLETE; read-data registers are unchanged.
  - The OK of the non-active direction is ignored.
- COMPLETE:
  - Exactly one cycle.
  - The granted port's Done = 1; both strobes = 0; no arbitration.
  - Next state is IDLE.
  - The requester must drop Req by the end of this cycle. A Req still high in IDLE is treated as a new request.
- Latency:
  - Req rises in cycle N; the strobe is asserted in N+1.
  - With OK in N+1, Done is asserted in N+2.
  - Minimum 3 cycles per access; back-to-back issue every 3 cycles.
- Requester inputs may change after grant; the access uses the values captured at grant.
- A Req that drops during ACCESS does not abort the access; Done is still pulsed.
- AddressBus and DataWriteBus hold their last values in IDLE and COMPLETE.
- BusError = 0 in all cycles unless BUS_TIMEOUT_EN aborts an access.

Optional Feature:
- BUS_TIMEOUT_EN defined:
  - An 8-bit-or-wider counter clears on entry to ACCESS and increments each ACCESS cycle without OK.
  - When the counter reaches TIMEOUT_CYCLES, go to COMPLETE with BusError = 1 for that Done cycle.
  - The read-data register is not updated on an aborted access.
  - If OK and the timeout occur in the same cycle, OK wins and BusError = 0.
- BUS_TIMEOUT_EN undefined: ACCESS waits indefinitely for OK; BusError is tied to 0; no counter is built.

Test Plan:
- Single fetch: FetchReq = 1, FetchAddr = 0x10, memory returns 0xDEADBEEF with ReadOK on the first ACCESS cycle -> ReadAssert high for 1 cycle, FetchDone pulses 2 cycles after Req, FetchData = 0xDEADBEEF, Grant = 0.
- Store with wait states: DataReq = 1, DataWe = 1, addr 0x20, data 0x12345678, WriteOK after 3 cycles -> AddressBus = 0x20, DataWriteBus = 0x12345678, WriteAssert high for exactly 4 cycles, DataDone 1 pulse, DataReadData unchanged.
- Contention: FetchReq and DataReq both held continuously for 4 accesses after reset -> grants go F, D, F, D; each Done is 1 cycle; 3-cycle spacing with zero-wait memory.
- Input change after grant: change FetchAddr from 0x4 to 0x8 during ACCESS -> AddressBus stays 0x4 until COMPLETE.
- Reset mid-access: assert CoreReset during ACCESS -> ReadAssert/WriteAssert = 0 immediately, no Done, state IDLE; fetch wins the first tie after release.
- BUS_TIMEOUT_EN with TIMEOUT_CYCLES = 5 and ReadOK never asserted -> DataDone and BusError = 1 in the same cycle after 5 ACCESS cycles; DataReadData unchanged; the next access completes normally with BusError = 0.
